// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_ctrl : pipeline stall/flush/bubble control, memory-wait timeout
//                     and saturating performance counters.
// Revision 1.0
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] STALL_MAX = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_kick_up,
  output logic        IF_kick_up,
  output logic        ID_kick_up,
  output logic        EX_kick_up,
  output logic        IF_flush,
  output logic        ID_bubble,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
);

  localparam int               WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]    C_TO    = WW'(TIMEOUT);
  localparam logic [WW-1:0]    C_WONE  = WW'(1);
  localparam logic [15:0]      C_FMAX  = 16'hFFFF;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic [31:0]   stall_q;
  logic [15:0]   flush_q;

  logic w_memstall;
  logic w_loaduse;
  logic w_flush_evt;

  assign w_memstall = mem_req & ~mem_ready;
  assign w_loaduse  = ex_memread & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_kick_up  = 1'b0;
    IF_kick_up  = 1'b0;
    ID_kick_up  = 1'b0;
    EX_kick_up  = 1'b0;
    IF_flush    = 1'b0;
    ID_bubble   = 1'b0;
    w_flush_evt = 1'b0;
    if (reset || state_q == S_ERR || w_memstall) begin
      // Full freeze: everything stays 0; a pending branch or load-use is
      // re-presented by the frozen EX stage on the release cycle.
    end else if (ex_branch_taken) begin
      pc_kick_up  = 1'b1;
      IF_kick_up  = 1'b1;
      ID_kick_up  = 1'b1;
      EX_kick_up  = 1'b1;
      IF_flush    = 1'b1;
      ID_bubble   = 1'b1;
      w_flush_evt = 1'b1;
    end else if (w_loaduse) begin
      ID_kick_up  = 1'b1;
      EX_kick_up  = 1'b1;
      ID_bubble   = 1'b1;
    end else begin
      pc_kick_up  = 1'b1;
      IF_kick_up  = 1'b1;
      ID_kick_up  = 1'b1;
      EX_kick_up  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      S_RUN: begin
        if (w_memstall) begin
          state_d = S_WAIT;
          wcnt_d  = C_WONE;
        end
      end
      S_WAIT: begin
        if (!w_memstall) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == C_TO) begin
          state_d       = S_ERR;
          mem_timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + C_WONE;
        end
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      if (state_q != S_ERR && !pc_kick_up && stall_q != STALL_MAX) begin
        stall_q <= stall_q + 32'd1;
      end
      if (w_flush_evt && flush_q != C_FMAX) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller that drives the `*_kick_up` enables, flush and bubble controls consumed by the PC, IF_ID, ID_EX and EX_MEM pipeline registers. It resolves three conditions: memory-wait freezes, taken-branch flushes and load-use hazards. It also enforces a memory-wait timeout and keeps saturating performance counters. It sits beside the ID stage, taking register indices from ID and hazard status from EX and MEM.

## Interface

Parameters:
- `TIMEOUT`, default 16: consecutive memory-stall cycles allowed before the controller enters ERR. Legal range is ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `id_rs1`, `id_rs2` input 5 each: source register indices of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` input 1 each: the ID instruction actually reads that source.
- `ex_memread` input 1: the instruction in EX is a load.
- `ex_rd` input 5: destination register of the EX instruction.
- `ex_branch_taken` input 1: the EX branch resolved as taken.
- `mem_req` input 1: the MEM stage has an outstanding data-memory access.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_kick_up`, `IF_kick_up`, `ID_kick_up`, `EX_kick_up` output 1 each: load enables for the PC, IF_ID, ID_EX and EX_MEM registers.
- `IF_flush` output 1: IF_ID loads a NOP this cycle.
- `ID_bubble` output 1: ID_EX loads all-zero control signals this cycle.
- `mem_timeout` output 1: sticky error flag.
- `stall_cycles` output 32: saturating count of stalled cycles.
- `flush_events` output 16: saturating count of branch flushes.

## Operation

- **States:** RUN, WAIT, ERR. Internal `wcnt` is `$clog2(TIMEOUT+1)` bits wide.
- **Condition signals** (combinational):
  - `memstall` = `mem_req & ~mem_ready`.
  - `loaduse` = `ex_memread & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- **Output priority** (combinational from state and inputs, highest first):
  1. `reset`=1 or state ERR: all kick_ups 0, `IF_flush`=0, `ID_bubble`=0.
  2. `memstall`, in RUN or WAIT: all kick_ups 0, `IF_flush`=0, `ID_bubble`=0 (full freeze).
  3. `ex_branch_taken`: all kick_ups 1, `IF_flush`=1, `ID_bubble`=1.
  4. `loaduse`: `pc_kick_up`=0, `IF_kick_up`=0, `ID_kick_up`=1, `EX_kick_up`=1, `ID_bubble`=1, `IF_flush`=0.
  5. Otherwise: all kick_ups 1, `IF_flush`=0, `ID_bubble`=0.
- **State transitions:**
  - RUN → WAIT when `memstall`; `wcnt` ← 1.
  - WAIT with `memstall`:
    - `wcnt`==`TIMEOUT` → ERR.
    - Otherwise `wcnt` ← `wcnt`+1.
  - WAIT with `~memstall` → RUN; `wcnt` ← 0. The release cycle applies priorities 3–5 in the same cycle.
  - ERR holds until `reset`; `mem_timeout`=1 in ERR.
- **Counters:**
  - `stall_cycles` increments in any non-reset, non-ERR cycle where `pc_kick_up`=0. It saturates at 0xFFFFFFFF.
  - `flush_events` increments on each cycle where priority 3 is active. It saturates at 0xFFFF.
- **Simultaneous events:**
  - A branch or load-use during a freeze is deferred. The frozen EX holds its inputs stable, so the branch or load-use is acted on in the release cycle.
  - A branch together with load-use resolves as the branch; the ID instruction is killed, so no bubble stall is needed.
- **Register x0:** an `ex_rd` of 0 never produces a load-use hazard.

## Timing

- **Reset values:** state RUN, `wcnt`=0, `mem_timeout`=0, `stall_cycles`=0, `flush_events`=0. While `reset`=1, all kick_ups are 0.
- **Control latency:** the kick_up, flush and bubble outputs are zero-latency (same cycle as the inputs).
- **State and counter latency:** `mem_timeout`, `stall_cycles` and `flush_events` update one cycle after the causing event.
- **Load-use stall length:** exactly 1 cycle. In the next cycle the load has moved to MEM, so `ex_memread` drops.
- **Timeout point:**
  - With `mem_ready` held low, the freeze lasts `TIMEOUT`+1 cycles in RUN/WAIT.
  - ERR is entered on the next edge, and `mem_timeout` rises that cycle.
  - `mem_ready` asserting on the last WAIT cycle (`wcnt`==`TIMEOUT`) avoids ERR.
- **Mid-operation reset:** reset asserted in WAIT or ERR forces RUN on the next edge and clears `mem_timeout` and both counters.

## Test plan

- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → one cycle of `pc_kick_up`=0, `IF_kick_up`=0, `ID_bubble`=1, `ID_kick_up`=1; `stall_cycles`=1 afterward. Repeat with `ex_rd`=0 → no stall.
- **Branch flush:** `ex_branch_taken`=1 with `loaduse` also true → all kick_ups 1, `IF_flush`=1, `ID_bubble`=1; `flush_events`=1 and `stall_cycles` unchanged.
- **Memory wait:** `mem_req`=1, `mem_ready` low for 3 cycles then high → 3 cycles of full freeze, release on cycle 4, `stall_cycles`=3, state returns to RUN.
- **Timeout:** `TIMEOUT`=4, `mem_ready` held low → 5 freeze cycles, then ERR with `mem_timeout`=1 and kick_ups 0 indefinitely. Raising `mem_ready` in ERR has no effect; `reset` for 1 cycle clears all state and counters.
- **Deferred branch:** `ex_branch_taken`=1 during a memory freeze → no flush while frozen; the flush occurs on the release cycle and `flush_events` increments once.
- **Saturation:** preload via a long forced stall (or use a shortened-counter build) → `stall_cycles` stops at all-ones and does not wrap.
